// File: rtl/core_mul_unit.sv
// Iterative 32x32 -> low-32 multiplier, one multiplier byte per cycle.
// Holds the result for writeback and masks its destination register meanwhile.
module core_mul_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_mul,
   input  logic [3:0]  dec_single,        // rd field of the decoded instruction
   input  logic [31:0] single_rd_value_a,
   input  logic [31:0] single_rd_value_b,
   input  logic        flush,
   input  logic        wb_ready,
   output logic        mul_busy,
   output logic [15:0] mask_mul,
   output logic        wb_valid,
   output logic [3:0]  wb_rd,
   output logic [31:0] wb_value
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  r_state;
   logic [1:0]  r_step;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_acc;
   logic [3:0]  r_rd;
   logic        w_accept;
   logic [31:0] w_partial;

   // A times one byte of B, aligned to that byte's weight; bits above 31 drop out.
   function automatic logic [31:0] f_partial(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [1:0]  step);
      logic [31:0] b_sh;
      logic [31:0] prod;
      b_sh = b >> {step, 3'b000};
      prod = a * {24'd0, b_sh[7:0]};
      return prod << {step, 3'b000};
   endfunction

   assign mul_busy  = (r_state == S_MUL) || ((r_state == S_DONE) && !wb_ready);
   assign w_accept  = start_mul && !flush && !mul_busy;
   assign w_partial = f_partial(r_a, r_b, r_step);

   assign wb_valid = (r_state == S_DONE);
   assign wb_value = r_acc;
   assign wb_rd    = r_rd;
   assign mask_mul = ((r_state == S_MUL) || (r_state == S_DONE)) ? (16'd1 << r_rd) : 16'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_step  <= 2'd0;
         r_acc   <= 32'd0;
         r_rd    <= 4'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
      end else if (flush) begin
         r_state <= S_IDLE;
      end else if (w_accept) begin
         r_a     <= single_rd_value_a;
         r_b     <= single_rd_value_b;
         r_rd    <= dec_single;
         r_acc   <= 32'd0;
         r_step  <= 2'd0;
         r_state <= S_MUL;
      end else if (r_state == S_MUL) begin
         r_acc  <= r_acc + w_partial;
         r_step <= r_step + 2'd1;
         if (r_step == 2'd3) r_state <= S_DONE;
      end else if ((r_state == S_DONE) && wb_ready) begin
         r_state <= S_IDLE;
      end else if (r_state == 2'd3) begin
         r_state <= S_IDLE;
      end
   end

endmodule

// File: tb/tb_core_mul_unit.sv
// Randomized plus directed bench for core_mul_unit with a transaction-level
// scoreboard: accepted ops are queued with their expected product and retired by a monitor.
module tb_core_mul_unit;

   logic        clk;
   logic        rst_n;
   logic        start_mul;
   logic [3:0]  dec_single;
   logic [31:0] single_rd_value_a;
   logic [31:0] single_rd_value_b;
   logic        flush;
   logic        wb_ready;
   logic        mul_busy;
   logic [15:0] mask_mul;
   logic        wb_valid;
   logic [3:0]  wb_rd;
   logic [31:0] wb_value;

   core_mul_unit dut (
      .clk(clk), .rst_n(rst_n), .start_mul(start_mul), .dec_single(dec_single),
      .single_rd_value_a(single_rd_value_a), .single_rd_value_b(single_rd_value_b),
      .flush(flush), .wb_ready(wb_ready), .mul_busy(mul_busy), .mask_mul(mask_mul),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_value(wb_value)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] v;
      logic [3:0]  rd;
      int          t;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_ret = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, got, exp);
      end
   endtask

   // Issue side: an op is taken when nothing is owned, or the owned result retires this edge.
   always @(posedge clk) begin
      logic owned;
      int   age;
      if (!rst_n || flush) begin
         q.delete();
      end else begin
         owned = 1'b0;
         if (q.size() > 0) begin
            age = cyc - q[0].t;
            if (age >= 4 && wb_ready) void'(q.pop_front());
            else owned = 1'b1;
         end
         if (start_mul && !owned)
            q.push_back('{single_rd_value_a * single_rd_value_b, dec_single, cyc + 1});
      end
      cyc++;
   end

   // Monitor: an op becomes valid four cycles after its first MUL cycle.
   always @(negedge clk) begin
      int   age;
      logic expv;
      if (!rst_n) begin
         chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
         chk("rst_mul_busy", {31'd0, mul_busy}, 32'd0);
         chk("rst_mask_mul", {16'd0, mask_mul}, 32'd0);
         chk("rst_wb_value", wb_value, 32'd0);
         chk("rst_wb_rd", {28'd0, wb_rd}, 32'd0);
      end else if (q.size() == 0) begin
         chk("idle_wb_valid", {31'd0, wb_valid}, 32'd0);
         chk("idle_mul_busy", {31'd0, mul_busy}, 32'd0);
         chk("idle_mask_mul", {16'd0, mask_mul}, 32'd0);
      end else begin
         age  = cyc - q[0].t;
         expv = (age >= 4);
         chk("wb_valid", {31'd0, wb_valid}, {31'd0, expv});
         chk("mask_mul", {16'd0, mask_mul}, {16'd0, 16'd1 << q[0].rd});
         chk("mul_busy", {31'd0, mul_busy}, {31'd0, !(expv && wb_ready)});
         if (expv) begin
            chk("wb_value", wb_value, q[0].v);
            chk("wb_rd", {28'd0, wb_rd}, {28'd0, q[0].rd});
            if (wb_ready && !flush) n_ret++;
         end
      end
   end

   task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] rd, input logic f, input logic r);
      start_mul         = s;
      single_rd_value_a = a;
      single_rd_value_b = b;
      dec_single        = rd;
      flush             = f;
      wb_ready          = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, r);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'hFFFFFFFF;
         1: return 32'h80000000;
         2: return 32'd0;
         3: return 32'(($urandom_range(0, 15)));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst_n = 1'b0;
      start_mul = 1'b0; dec_single = 4'd0; flush = 1'b0; wb_ready = 1'b0;
      single_rd_value_a = 32'd0; single_rd_value_b = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2, 1'b1);

      drive(1'b1, 32'd7, 32'd6, 4'd3, 1'b0, 1'b1);
      idle(7, 1'b1);
      drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1, 1'b0, 1'b1);
      idle(6, 1'b1);
      drive(1'b1, 32'h12345678, 32'h9ABCDEF0, 4'd15, 1'b0, 1'b1);
      idle(6, 1'b1);
      drive(1'b1, 32'h80000000, 32'd2, 4'd0, 1'b0, 1'b1);
      idle(6, 1'b1);

      // Writeback stalls for ten DONE cycles, then a single-cycle handshake.
      drive(1'b1, 32'hDEADBEEF, 32'h01020304, 4'd5, 1'b0, 1'b0);
      idle(14, 1'b0);
      idle(1, 1'b1);
      idle(3, 1'b0);

      // Flush in MUL with a concurrent start.
      drive(1'b1, 32'd11, 32'd13, 4'd6, 1'b0, 1'b1);
      idle(1, 1'b1);
      drive(1'b1, 32'd99, 32'd99, 4'd7, 1'b1, 1'b1);
      idle(8, 1'b1);

      // Flush in DONE while writeback is ready, again with a concurrent start.
      drive(1'b1, 32'd21, 32'd2, 4'd8, 1'b0, 1'b0);
      idle(6, 1'b0);
      drive(1'b1, 32'd5, 32'd5, 4'd9, 1'b1, 1'b1);
      idle(8, 1'b1);

      // Back-to-back: the second op starts in the retire cycle of the first.
      drive(1'b1, 32'd3, 32'd5, 4'd2, 1'b0, 1'b0);
      idle(4, 1'b0);
      drive(1'b1, 32'd9, 32'd9, 4'd4, 1'b0, 1'b1);
      idle(8, 1'b1);

      // A start during MUL must be ignored.
      drive(1'b1, 32'd1000, 32'd1000, 4'd10, 1'b0, 1'b1);
      idle(1, 1'b1);
      drive(1'b1, 32'd7, 32'd7, 4'd11, 1'b0, 1'b1);
      idle(8, 1'b1);

      // Asynchronous reset in the middle of an operation.
      drive(1'b1, 32'h55555555, 32'h3, 4'd12, 1'b0, 1'b1);
      idle(2, 1'b1);
      rst_n = 1'b0;
      #2;
      chk("async_rst_valid", {31'd0, wb_valid}, 32'd0);
      chk("async_rst_mask", {16'd0, mask_mul}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(8, 1'b1);

      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 99) < 40), pick_operand(), pick_operand(),
               4'($urandom_range(0, 15)), ($urandom_range(0, 99) < 4),
               ($urandom_range(0, 99) < 70));
      end
      idle(10, 1'b1);

      n_cmp++;
      if (n_ret < 10) begin
         n_bad++;
         $display("FAIL retire_count: got %0d retired results, required at least 10", n_ret);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
